fma16_arbiter_ctrl: RTL and testbench

- Shares one half-precision FMA datapath (fma16 with its special-case/flag logic) between two requesters.
- Arbitrates round-robin and registers operands and the op controls.
- Holds the datapath inputs stable for a fixed multi-cycle evaluation window, then captures the result and flags.
- Returns each result on a response channel and keeps per-requester sticky IEEE flags (NV, OF, UF, NX).

---
 rtl/fma16_arbiter_ctrl.sv | 164 ++++++++++++++++
 tb/tb_fma16_arbiter_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma16_arbiter_ctrl.sv
// fma16_arbiter_ctrl: round-robin front end that shares one fma16 datapath
// between two requesters. Holds operands for LATENCY cycles, captures the
// result and flags, returns them on a response channel and keeps per-requester
// sticky IEEE flags {NV, OF, UF, NX}.
// Optional feature: define FMA16_ARB_CANON_NAN_EN to replace any NaN result
// (or any result flagged NV) with the canonical quiet NaN 0x7e00.
module fma16_arbiter_ctrl #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    input  logic [31:0] req_z,
    input  logic [7:0]  req_op,
    input  logic [3:0]  req_rm,
    output logic [15:0] dp_x,
    output logic [15:0] dp_y,
    output logic [15:0] dp_z,
    output logic [3:0]  dp_op,
    output logic [1:0]  dp_rm,
    input  logic [15:0] dp_result,
    input  logic [3:0]  dp_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic [7:0]  fflags,
    input  logic [1:0]  fflags_clr,
    output logic        busy
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned FLAG_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic              ptr;
    logic [CNT_W-1:0]  cnt;
    logic              grantValid;
    logic              grantId;
    logic              reqFire;
    logic              rspFire;
    logic              evalDone;
    logic [DATA_W-1:0] capResult;

    // Round-robin pick: the pointer requester wins a tie, otherwise whoever is valid
    always_comb begin
        grantValid = req_valid[ptr] | req_valid[~ptr];
        grantId    = req_valid[ptr] ? ptr : ~ptr;
    end

    assign evalDone = (state == EXEC) && (cnt == '0);

    // Result as presented to the response channel (optionally canonicalising NaNs)
    always_comb begin
        capResult = dp_result;
`ifdef FMA16_ARB_CANON_NAN_EN
        if (dp_flags[3] || ((dp_result[14:10] == 5'h1f) && (dp_result[9:0] != 10'h000))) begin
            capResult = 16'h7e00;
        end
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, request accept and response handshake decode
    always_comb begin
        stateNext = state;
        req_ready = 2'b00;
        reqFire   = 1'b0;
        rspFire   = 1'b0;
        case (state)
            IDLE: begin
                if (grantValid) begin
                    req_ready[grantId] = 1'b1;
                    reqFire            = 1'b1;
                    stateNext          = EXEC;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rspFire   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    // Operand latch, evaluation counter, result capture and fairness pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp_x       <= '0;
            dp_y       <= '0;
            dp_z       <= '0;
            dp_op      <= '0;
            dp_rm      <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            cnt        <= '0;
            ptr        <= 1'b0;
        end else begin
            if (reqFire) begin
                dp_x   <= grantId ? req_x[31:16] : req_x[15:0];
                dp_y   <= grantId ? req_y[31:16] : req_y[15:0];
                dp_z   <= grantId ? req_z[31:16] : req_z[15:0];
                dp_op  <= grantId ? req_op[7:4]  : req_op[3:0];
                dp_rm  <= grantId ? req_rm[3:2]  : req_rm[1:0];
                rsp_id <= grantId;
                cnt    <= CNT_W'(LATENCY - 1);
            end else if ((state == EXEC) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (evalDone) begin
                rsp_result <= capResult;
                rsp_flags  <= dp_flags;
            end
            if (rspFire) begin
                ptr <= ~rsp_id;
            end
        end
    end

    // Sticky flags: a clear and a new set in the same cycle keep only the new flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fflags <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                fflags[FLAG_W*i +: FLAG_W] <=
                    (fflags_clr[i] ? {FLAG_W{1'b0}} : fflags[FLAG_W*i +: FLAG_W]) |
                    ((rspFire && (rsp_id == 1'(i))) ? rsp_flags : {FLAG_W{1'b0}});
            end
        end
    end

endmodule

// File: tb/tb_fma16_arbiter_ctrl.sv
// Bench for fma16_arbiter_ctrl: a scoreboard of expected responses is filled
// as requests are issued and drained as responses are accepted.
module tb_fma16_arbiter_ctrl;

    localparam int unsigned LAT = 2;

    typedef struct packed {
        logic        id;
        logic [15:0] res;
        logic [3:0]  flg;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_x, req_y, req_z;
    logic [7:0]  req_op;
    logic [3:0]  req_rm;
    logic [15:0] dp_x, dp_y, dp_z;
    logic [3:0]  dp_op;
    logic [1:0]  dp_rm;
    logic [15:0] dp_result;
    logic [3:0]  dp_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [7:0]  fflags;
    logic [1:0]  fflags_clr;
    logic        busy;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [7:0]  expF = 8'h00;
    logic        modelFn = 1'b0;
    logic [15:0] modelRes = 16'h0000;
    logic [3:0]  modelFlg = 4'h0;

    fma16_arbiter_ctrl #(.LATENCY(LAT), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z),
        .req_op(req_op), .req_rm(req_rm),
        .dp_x(dp_x), .dp_y(dp_y), .dp_z(dp_z), .dp_op(dp_op), .dp_rm(dp_rm),
        .dp_result(dp_result), .dp_flags(dp_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .fflags(fflags), .fflags_clr(fflags_clr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: either a fixed result or a simple function of the operands
    assign dp_result = modelFn ? 16'(dp_x + dp_y) : modelRes;
    assign dp_flags  = modelFn ? dp_z[3:0] : modelFlg;

    function automatic logic [15:0] expRes(input logic [15:0] r, input logic [3:0] f);
`ifdef FMA16_ARB_CANON_NAN_EN
        if (f[3] || ((r[14:10] == 5'h1f) && (r[9:0] != 10'h000))) return 16'h7e00;
`endif
        return r;
    endfunction

    function automatic exp_t mkExp(input logic id);
        logic [15:0] x, y, z, r;
        logic [3:0]  f;
        exp_t e;
        x = id ? req_x[31:16] : req_x[15:0];
        y = id ? req_y[31:16] : req_y[15:0];
        z = id ? req_z[31:16] : req_z[15:0];
        r = modelFn ? 16'(x + y) : modelRes;
        f = modelFn ? z[3:0] : modelFlg;
        e.id  = id;
        e.res = expRes(r, f);
        e.flg = f;
        return e;
    endfunction

    task automatic setReq(input int i, input logic [15:0] x, input logic [15:0] y,
                          input logic [15:0] z, input logic [3:0] op, input logic [1:0] rm);
        if (i == 0) begin
            req_x[15:0] = x; req_y[15:0] = y; req_z[15:0] = z;
            req_op[3:0] = op; req_rm[1:0] = rm; req_valid[0] = 1'b1;
        end else begin
            req_x[31:16] = x; req_y[31:16] = y; req_z[31:16] = z;
            req_op[7:4] = op; req_rm[3:2] = rm; req_valid[1] = 1'b1;
        end
    endtask

    task automatic doHs(output bit ok, output logic g);
        ok = 1'b0;
        g  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != 2'b00) begin
                ok = 1'b1;
                g  = req_ready[1];
            end
            @(posedge clk);
            #1;
            if (ok) break;
        end
    endtask

    task automatic waitRsp(output bit got, output int cyc);
        cyc = 1;
        while (!rsp_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        got = rsp_valid;
    endtask

    // Push the expectation, wait for the grant, then wait for the response
    task automatic serve(input exp_t e, output bit ok, output logic g, output bit got, output int cyc);
        sb.push_back(e);
        doHs(ok, g);
        waitRsp(got, cyc);
    endtask

    task automatic rspAccept(input logic [1:0] clr, input exp_t e);
        rsp_ready  = 1'b1;
        fflags_clr = clr;
        @(posedge clk);
        #1;
        rsp_ready  = 1'b0;
        fflags_clr = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (clr[i]) expF[4*i +: 4] = 4'h0;
        end
        if (e.id) expF[7:4] = expF[7:4] | e.flg;
        else      expF[3:0] = expF[3:0] | e.flg;
    endtask

    task automatic test_reset;
        checks++;
        if ({req_ready, dp_x, dp_y, dp_z, dp_op, dp_rm, rsp_valid, rsp_id, rsp_result,
             rsp_flags, fflags, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0d rsp_valid=%0d fflags=%h dp_x=%h, required all zero",
                     busy, rsp_valid, fflags, dp_x);
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({busy, rsp_valid, fflags, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_release: busy=%0d rsp_valid=%0d fflags=%h req_ready=%b, required 0",
                     busy, rsp_valid, fflags, req_ready);
        end
    endtask

    task automatic test_single;
        exp_t e; bit ok; logic g; bit got; int cyc;
        modelFn = 1'b0; modelRes = 16'h4200; modelFlg = 4'h0;
        setReq(0, 16'h3c00, 16'h4000, 16'h3c00, 4'b1100, 2'b00);
        e = mkExp(1'b0);
        serve(e, ok, g, got, cyc);
        checks++;
        if (!ok || g !== 1'b0) begin
            errors++; $display("FAIL single_grant: ok=%0d grant=%0d, required grant 0", ok, g);
        end
        checks++;
        if (cyc != int'(LAT + 1) || !got) begin
            errors++; $display("FAIL single_latency: %0d cycles (valid=%0d), required %0d", cyc, got, LAT + 1);
        end
        checks++;
        if ({dp_x, dp_y, dp_z, dp_op, dp_rm, busy, req_ready} !== {16'h3c00, 16'h4000, 16'h3c00, 4'b1100, 2'b00, 1'b1, 2'b00}) begin
            errors++; $display("FAIL single_dp: x=%h y=%h z=%h op=%b rm=%b busy=%0d ready=%b", dp_x, dp_y, dp_z, dp_op, dp_rm, busy, req_ready);
        end
        e = sb.pop_front();
        checks++;
        if ({rsp_id, rsp_result, rsp_flags} !== {1'b0, 16'h4200, 4'h0} || e.res !== 16'h4200) begin
            errors++; $display("FAIL single_rsp: id=%0d res=%h flg=%h, required id=0 res=4200 flg=0", rsp_id, rsp_result, rsp_flags);
        end
        req_valid = 2'b00;
        rspAccept(2'b00, e);
        checks++;
        if ({rsp_valid, busy, fflags} !== {1'b0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL single_done: rsp_valid=%0d busy=%0d fflags=%h, required 0 0 00", rsp_valid, busy, fflags);
        end
    endtask

    task automatic test_tie;
        exp_t e; bit ok; logic g; bit got; int cyc;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        expF = 8'h00;
        modelFn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            setReq(0, 16'h1100 + 16'(k), 16'h0011, 16'h0000, 4'b1100, 2'b01);
            setReq(1, 16'h2200 + 16'(k), 16'h0022, 16'h0003, 4'b1110, 2'b10);
            e = mkExp(1'(k));
            serve(e, ok, g, got, cyc);
            checks++;
            if (!ok || g !== 1'(k)) begin
                errors++; $display("FAIL tie_grant%0d: ok=%0d grant=%0d, required %0d", k, ok, g, k % 2);
            end
            e = sb.pop_front();
            checks++;
            if (!got || {rsp_id, rsp_result, rsp_flags} !== {e.id, e.res, e.flg}) begin
                errors++; $display("FAIL tie_rsp%0d: id=%0d res=%h flg=%h, required id=%0d res=%h flg=%h",
                                   k, rsp_id, rsp_result, rsp_flags, e.id, e.res, e.flg);
            end
            if (k == 3) req_valid = 2'b00;
            rspAccept(2'b00, e);
        end
        checks++;
        if (fflags !== expF || fflags !== 8'h30) begin
            errors++; $display("FAIL tie_fflags: %h, required 30", fflags);
        end
        modelFn = 1'b0;
    endtask

    task automatic test_backpressure;
        exp_t e; bit ok; logic g; bit got; int cyc;
        modelRes = 16'h1234; modelFlg = 4'h2;
        setReq(0, 16'h0101, 16'h0202, 16'h0303, 4'b1000, 2'b11);
        e = mkExp(1'b0);
        serve(e, ok, g, got, cyc);
        checks++;
        if (!ok || !got || g !== 1'b0) begin
            errors++; $display("FAIL bp_issue: ok=%0d got=%0d grant=%0d, required 1 1 0", ok, got, g);
        end
        req_valid = 2'b11;
        modelRes  = 16'hdead;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_result, rsp_flags, req_ready, busy} !== {1'b1, 1'b0, 16'h1234, 4'h2, 2'b00, 1'b1}) begin
                errors++; $display("FAIL bp_hold%0d: valid=%0d id=%0d res=%h flg=%h ready=%b busy=%0d, required 1 0 1234 2 00 1",
                                   k, rsp_valid, rsp_id, rsp_result, rsp_flags, req_ready, busy);
            end
        end
        req_valid = 2'b00;
        e = sb.pop_front();
        rspAccept(2'b00, e);
        checks++;
        if ({rsp_valid, busy, fflags} !== {1'b0, 1'b0, expF}) begin
            errors++; $display("FAIL bp_release: valid=%0d busy=%0d fflags=%h, required 0 0 %h", rsp_valid, busy, fflags, expF);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, busy} !== 2'b00) begin
            errors++; $display("FAIL bp_idle: valid=%0d busy=%0d, required 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_sticky;
        exp_t e; bit ok; logic g; bit got; int cyc;
        logic [3:0] flgs [3];
        flgs[0] = 4'h1; flgs[1] = 4'h4; flgs[2] = 4'h8;
        fflags_clr = 2'b11;
        @(posedge clk);
        #1;
        fflags_clr = 2'b00;
        expF = 8'h00;
        checks++;
        if (fflags !== 8'h00) begin
            errors++; $display("FAIL sticky_clear: %h, required 00", fflags);
        end
        for (int k = 0; k < 3; k++) begin
            modelRes = 16'h4000 + 16'(k); modelFlg = flgs[k];
            setReq(1, 16'h4000, 16'h3c00, 16'h0000, 4'b1100, 2'b00);
            e = mkExp(1'b1);
            serve(e, ok, g, got, cyc);
            req_valid = 2'b00;
            e = sb.pop_front();
            checks++;
            if (!ok || !got || g !== 1'b1 || {rsp_id, rsp_result, rsp_flags} !== {e.id, e.res, e.flg}) begin
                errors++; $display("FAIL sticky_rsp%0d: grant=%0d id=%0d res=%h flg=%h, required id=1 res=%h flg=%h",
                                   k, g, rsp_id, rsp_result, rsp_flags, e.res, e.flg);
            end
            rspAccept((k == 2) ? 2'b10 : 2'b00, e);
            if (k == 1) begin
                checks++;
                if (fflags[7:4] !== 4'h5) begin
                    errors++; $display("FAIL sticky_accum: %h, required 5", fflags[7:4]);
                end
            end
        end
        checks++;
        if (fflags !== 8'h80 || fflags !== expF) begin
            errors++; $display("FAIL sticky_clr_set: %h, required 80", fflags);
        end
    endtask

    task automatic test_nan;
        exp_t e; bit ok; logic g; bit got; int cyc;
        logic [19:0] tbl [3];
        logic [15:0] want0;
        tbl[0] = {16'hfd01, 4'h8}; tbl[1] = {16'h7c01, 4'h0}; tbl[2] = {16'h7c00, 4'h1};
`ifdef FMA16_ARB_CANON_NAN_EN
        want0 = 16'h7e00;
`else
        want0 = 16'hfd01;
`endif
        for (int k = 0; k < 3; k++) begin
            modelRes = tbl[k][19:4]; modelFlg = tbl[k][3:0];
            setReq(0, 16'h7c00, 16'h0000, 16'h0000, 4'b1000, 2'b00);
            e = mkExp(1'b0);
            serve(e, ok, g, got, cyc);
            req_valid = 2'b00;
            e = sb.pop_front();
            checks++;
            if (!ok || !got || {rsp_id, rsp_result, rsp_flags} !== {e.id, e.res, e.flg} ||
                (k == 0 && rsp_result !== want0)) begin
                errors++; $display("FAIL nan%0d: res=%h flg=%h, required res=%h flg=%h", k, rsp_result, rsp_flags, e.res, e.flg);
            end
            rspAccept(2'b00, e);
        end
    endtask

    task automatic test_reset_mid;
        exp_t e; bit ok; logic g; bit got; int cyc; bit seen;
        modelRes = 16'h5555; modelFlg = 4'h1;
        setReq(0, 16'h1111, 16'h2222, 16'h3333, 4'b0100, 2'b01);
        e = mkExp(1'b0);
        sb.push_back(e);
        doHs(ok, g);
        reset_n   = 1'b0;
        req_valid = 2'b00;
        #1;
        checks++;
        if ({req_ready, dp_x, dp_y, dp_z, dp_op, dp_rm, rsp_valid, rsp_id, rsp_result,
             rsp_flags, fflags, busy} !== '0 || !ok) begin
            errors++; $display("FAIL midreset_outputs: ok=%0d busy=%0d dp_x=%h fflags=%h, required zero", ok, busy, dp_x, fflags);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb.delete();
        expF = 8'h00;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL midreset_abort: rsp_valid/busy seen=1, required 0");
        end
        setReq(1, 16'h4444, 16'h5555, 16'h6666, 4'b1100, 2'b10);
        e = mkExp(1'b1);
        serve(e, ok, g, got, cyc);
        req_valid = 2'b00;
        e = sb.pop_front();
        checks++;
        if (!ok || !got || g !== 1'b1 || cyc != int'(LAT + 1) ||
            {rsp_id, rsp_result, rsp_flags} !== {e.id, e.res, e.flg} || dp_x !== 16'h4444) begin
            errors++; $display("FAIL midreset_next: grant=%0d cyc=%0d id=%0d res=%h flg=%h, required id=1 res=%h flg=%h",
                               g, cyc, rsp_id, rsp_result, rsp_flags, e.res, e.flg);
        end
        rspAccept(2'b00, e);
        checks++;
        if (fflags !== expF || fflags !== 8'h10) begin
            errors++; $display("FAIL midreset_fflags: %h, required 10", fflags);
        end
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 2'b00; req_x = '0; req_y = '0; req_z = '0;
        req_op = '0; req_rm = '0; rsp_ready = 1'b0; fflags_clr = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        test_single;
        test_tie;
        test_backpressure;
        test_sticky;
        test_nan;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
